// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//   Clock-synchronous I2C master. One command = START, {chip_addr, rw} byte,
//   nb_bytes data bytes, STOP. Each SCL bit is split into four quarters
//   q0..q3, each G_CLK_DIV clk long:
//     q0 SCL low, SDA may change; q1 SCL low; q2 SCL released; q3 SCL high.
//   SDA is sampled on the last clk of q2. SCL is never read back.
//   The FSM state is held in `state` (type state_t) so probes can observe it.
//
// Handshakes:
//   start      : strobe, accepted only in IDLE (ignored while busy).
//   wdata_req  : one-cycle pulse; wdata is captured in that same cycle, so the
//                source presents the following byte only after the pulse.
//   rdata_valid: one-cycle pulse; rdata holds the byte until the next pulse.
//   done       : one-cycle pulse after STOP completes; busy drops with it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, chip_addr, rw, nb_bytes   command (latched on accepted start)
//   wdata, wdata_req  write byte stream
//   rdata, rdata_valid read byte stream
//   busy, done, nack_err  status
//   sclk, sda         open-drain bus lines (drive 0 or Z only)
// -----------------------------------------------------------------------------
module i2c_master #(
    parameter int G_CLK_DIV        = 25,
    parameter int G_NB_BYTES_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [6:0]                  chip_addr,
    input  logic                        rw,
    input  logic [G_NB_BYTES_WIDTH-1:0] nb_bytes,
    input  logic [7:0]                  wdata,
    output logic                        wdata_req,
    output logic [7:0]                  rdata,
    output logic                        rdata_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        nack_err,
    inout  wire                         sclk,
    inout  wire                         sda
);

    localparam int TW = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(G_CLK_DIV - 1);
    localparam logic [G_NB_BYTES_WIDTH-1:0] ONE_LEFT = G_NB_BYTES_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP
    } state_t;

    state_t                        state, state_nxt;
    logic [TW-1:0]                 tick_cnt;
    logic [1:0]                    q;
    logic [2:0]                    bit_idx;
    logic [7:0]                    shift;
    logic [G_NB_BYTES_WIDTH-1:0]   byte_cnt;
    logic                          rw_r;
    logic                          sda_smp;
    logic                          scl_low, sda_low;
    logic                          sda_in;
    logic                          tick_end, bit_end, sample_pt;

    assign sclk   = scl_low ? 1'b0 : 1'bz;
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign tick_end  = (tick_cnt == TICK_LAST);
    assign bit_end   = tick_end && (q == 2'd3);
    assign sample_pt = tick_end && (q == 2'd2);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: every non-idle transition happens at the end of a bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_START;
            S_START:    if (bit_end) state_nxt = S_ADDR;
            S_ADDR:     if (bit_end && bit_idx == 3'd0) state_nxt = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) begin
                            if (sda_smp || byte_cnt == '0) state_nxt = S_STOP;
                            else if (rw_r)                 state_nxt = S_RD;
                            else                           state_nxt = S_WR;
                        end
            S_WR:       if (bit_end && bit_idx == 3'd0) state_nxt = S_WR_ACK;
            S_WR_ACK:   if (bit_end) state_nxt = (sda_smp || byte_cnt == ONE_LEFT) ? S_STOP : S_WR;
            S_RD:       if (bit_end && bit_idx == 3'd0) state_nxt = S_RD_ACK;
            S_RD_ACK:   if (bit_end) state_nxt = (byte_cnt == ONE_LEFT) ? S_STOP : S_RD;
            S_STOP:     if (bit_end) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output logic: bus line drive and request strobe
    always_comb begin
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        busy      = (state != S_IDLE);
        wdata_req = (state == S_WR) && (q == 2'd0) && (tick_cnt == '0) && (bit_idx == 3'd7);
        case (state)
            S_START: begin
                scl_low = (q == 2'd3);
                sda_low = (q >= 2'd2);
            end
            S_ADDR: begin
                scl_low = (q < 2'd2);
                sda_low = ~shift[7];
            end
            S_WR: begin
                scl_low = (q < 2'd2);
                // On the capture cycle the shift register still holds the old
                // byte; drive the incoming MSB directly to avoid a glitch.
                sda_low = wdata_req ? ~wdata[7] : ~shift[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD: scl_low = (q < 2'd2);
            S_RD_ACK: begin
                scl_low = (q < 2'd2);
                sda_low = (byte_cnt != ONE_LEFT);   // ACK unless last byte
            end
            S_STOP: begin
                scl_low = (q == 2'd0);
                sda_low = (q != 2'd3);
            end
            default: ;
        endcase
    end

    // Datapath: timing counters, shift register, byte counter, status
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt    <= '0;
            q           <= 2'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            byte_cnt    <= '0;
            rw_r        <= 1'b0;
            sda_smp     <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            nack_err    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            if (state == S_IDLE) begin
                tick_cnt <= '0;
                q        <= 2'd0;
                bit_idx  <= 3'd7;
                if (start) begin
                    shift    <= {chip_addr, rw};
                    rw_r     <= rw;
                    byte_cnt <= nb_bytes;
                    nack_err <= 1'b0;
                end
            end else begin
                if (tick_end) begin
                    tick_cnt <= '0;
                    q        <= q + 2'd1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                if (sample_pt) sda_smp <= sda_in;
                case (state)
                    S_ADDR: if (bit_end) begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_idx <= bit_idx - 3'd1;   // wraps 0 -> 7 for next byte
                    end
                    S_WR: begin
                        if (wdata_req) shift <= wdata;
                        else if (bit_end) begin
                            shift   <= {shift[6:0], 1'b0};
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                    S_RD: begin
                        if (sample_pt) begin
                            shift <= {shift[6:0], sda_in};
                            if (bit_idx == 3'd0) begin
                                rdata       <= {shift[6:0], sda_in};
                                rdata_valid <= 1'b1;
                            end
                        end
                        if (bit_end) bit_idx <= bit_idx - 3'd1;
                    end
                    S_ADDR_ACK: if (bit_end && sda_smp) nack_err <= 1'b1;
                    S_WR_ACK: if (bit_end) begin
                        if (sda_smp) nack_err <= 1'b1;
                        else         byte_cnt <= byte_cnt - 1'b1;
                    end
                    S_RD_ACK: if (bit_end) byte_cnt <= byte_cnt - 1'b1;
                    S_STOP:   if (bit_end) done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
//   Bench for i2c_master with G_CLK_DIV=4. A behavioural I2C slave (address
//   0x50) ACKs writes and serves read bytes from slv_tx_q. A bus monitor
//   decodes the wires into tokens (START, STOP, byte+ack) which are compared
//   with the token list predicted from each command.
// -----------------------------------------------------------------------------
module tb_i2c_master;

    localparam int CLK_DIV = 4;
    localparam int NBW     = 8;
    localparam logic [6:0] SLV_ADDR  = 7'h50;
    localparam logic [9:0] TOK_START = 10'h200;
    localparam logic [9:0] TOK_STOP  = 10'h300;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [6:0]     chip_addr = 7'h00;
    logic           rw = 1'b0;
    logic [NBW-1:0] nb_bytes = '0;
    logic [7:0]     wdata = 8'h00;
    logic           wdata_req, rdata_valid, busy, done, nack_err;
    logic [7:0]     rdata;
    wire            sclk, sda;

    pullup (sclk);
    pullup (sda);

    logic s_low = 1'b0;
    assign sda = s_low ? 1'b0 : 1'bz;

    i2c_master #(.G_CLK_DIV(CLK_DIV), .G_NB_BYTES_WIDTH(NBW)) dut (
        .clk(clk), .rst(rst), .start(start), .chip_addr(chip_addr), .rw(rw),
        .nb_bytes(nb_bytes), .wdata(wdata), .wdata_req(wdata_req),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
        .nack_err(nack_err), .sclk(sclk), .sda(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [9:0] bus_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wr_bytes[$];
    logic [7:0] slv_tx_q[$];
    logic [7:0] txn_data[$];
    int req_cnt = 0;
    int done_cnt = 0;
    int wr_idx = 0;
    int mon_rises = 0;
    int rise_t[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: START/STOP on SDA edges with SCL high, bytes on SCL rises
    initial begin
        logic scl_p, sda_p, scl_c, sda_c;
        logic [7:0] sh;
        int n;
        scl_p = 1'b1; sda_p = 1'b1; sh = 8'h00; n = 0;
        forever begin
            @(negedge clk);
            scl_c = sclk; sda_c = sda;
            if (scl_p && scl_c && sda_p && !sda_c) begin
                bus_q.push_back(TOK_START);
                n = 0;
                mon_rises = 0;
            end else if (scl_p && scl_c && !sda_p && sda_c) begin
                bus_q.push_back(TOK_STOP);
            end else if (!scl_p && scl_c) begin
                if (mon_rises < 4) rise_t[mon_rises] = cyc;
                mon_rises++;
                if (n == 8) begin
                    bus_q.push_back({1'b0, sda_c, sh});
                    n = 0;
                end else begin
                    sh = {sh[6:0], sda_c};
                    n++;
                end
            end
            scl_p = scl_c; sda_p = sda_c;
        end
    end

    // Behavioural slave at SLV_ADDR
    initial begin
        logic scl_p, sda_p, scl_c, sda_c, addressed, tx, sending, mack;
        logic [7:0] sh, txb;
        int n, bidx;
        scl_p = 1'b1; sda_p = 1'b1; addressed = 1'b0; tx = 1'b0; sending = 1'b0;
        mack = 1'b1; sh = 8'h00; txb = 8'hFF; n = 0; bidx = 0;
        forever begin
            @(negedge clk);
            scl_c = sclk; sda_c = sda;
            if (scl_p && scl_c && sda_p && !sda_c) begin
                n = 0; bidx = 0; addressed = 1'b0; tx = 1'b0; sending = 1'b0; s_low = 1'b0;
            end else if (scl_p && scl_c && !sda_p && sda_c) begin
                addressed = 1'b0; tx = 1'b0; sending = 1'b0; s_low = 1'b0;
            end else if (!scl_p && scl_c) begin
                if (n < 8) sh = {sh[6:0], sda_c};
                else       mack = sda_c;
                n++;
            end else if (scl_p && !scl_c) begin
                if (n == 8) begin
                    sending = 1'b0;
                    if (bidx == 0) begin
                        addressed = (sh[7:1] == SLV_ADDR);
                        tx = sh[0];
                        s_low = addressed;
                    end else begin
                        s_low = addressed && !tx;
                    end
                end else if (n == 9) begin
                    n = 0;
                    if (addressed && tx && (bidx == 0 || !mack)) begin
                        txb = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'hFF;
                        sending = 1'b1;
                        s_low = !txb[7];
                    end else begin
                        s_low = 1'b0;
                    end
                    bidx++;
                end else if (sending && n >= 1 && n <= 7) begin
                    s_low = !txb[7-n];
                end
            end
            scl_p = scl_c; sda_p = sda_c;
        end
    end

    // Write-data source: next byte is presented after the capture cycle
    initial begin
        forever begin
            @(negedge clk);
            if (wdata_req) begin
                req_cnt++;
                @(posedge clk); #1;
                wr_idx++;
                wdata = (wr_idx < wr_bytes.size()) ? wr_bytes[wr_idx] : 8'h00;
            end
        end
    end

    // Read-data and done collector
    initial begin
        forever begin
            @(negedge clk);
            if (rdata_valid) rd_q.push_back(rdata);
            if (done) done_cnt++;
        end
    end

    task automatic launch(input logic [6:0] a, input logic r, input int n);
        bus_q.delete(); rd_q.delete();
        req_cnt = 0; done_cnt = 0; wr_idx = 0;
        wr_bytes = txn_data;
        slv_tx_q = txn_data;
        wdata = (!r && n > 0) ? txn_data[0] : 8'h00;
        @(posedge clk); #1;
        chip_addr = a; rw = r; nb_bytes = NBW'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble command inputs: they must have been latched
        chip_addr = 7'($urandom_range(0, 127)); rw = 1'($urandom_range(0, 1));
        nb_bytes = NBW'($urandom_range(0, 255));
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input int n,
                           input bit glitch, input string tag);
        logic [9:0] exp_bus[$];
        logic [7:0] exp_rd[$];
        bit acked;
        int exp_req, waited, budget;
        acked = (a == SLV_ADDR);
        exp_req = 0;
        exp_bus.push_back(TOK_START);
        exp_bus.push_back({1'b0, !acked, a, r});
        if (acked) begin
            for (int i = 0; i < n; i++) begin
                if (r) begin
                    exp_bus.push_back({1'b0, (i == n - 1), txn_data[i]});
                    exp_rd.push_back(txn_data[i]);
                end else begin
                    exp_bus.push_back({1'b0, 1'b0, txn_data[i]});
                    exp_req++;
                end
            end
        end
        exp_bus.push_back(TOK_STOP);

        launch(a, r, n);
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        budget = (n + 3) * 9 * 4 * CLK_DIV + 100;
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            @(posedge clk); #1;
            waited++;
            if (glitch && waited == 60) begin
                chip_addr = 7'h21; rw = ~r; nb_bytes = NBW'(7); start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                waited++;
            end
        end
        chk({tag, "_done_in_time"}, 32'(done_cnt != 0), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_nack_err"}, 32'(nack_err), 32'(!acked));
        chk({tag, "_wdata_req_count"}, 32'(req_cnt), 32'(exp_req));
        chk({tag, "_bus_len"}, 32'(bus_q.size()), 32'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size(); i++)
            chk($sformatf("%s_bus%0d", tag, i),
                (i < bus_q.size()) ? 32'(bus_q[i]) : 32'hFFFF_FFFF, 32'(exp_bus[i]));
        chk({tag, "_rd_len"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i),
                (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF_FFFF, 32'(exp_rd[i]));
    endtask

    initial begin
        int w;
        logic [6:0] ra;
        logic rr;
        int rn;

        // Reset state, with start held high to show reset wins
        rst = 1'b1; start = 1'b1; chip_addr = SLV_ADDR;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wdata_req", 32'(wdata_req), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_nack_err", 32'(nack_err), 32'd0);
        @(posedge clk); #1;
        chk("rst_start_ignored", 32'(busy), 32'd0);

        // Write two bytes; SCL period from monitor timestamps
        txn_data = '{8'hA5, 8'h3C};
        run_txn(SLV_ADDR, 1'b0, 2, 1'b0, "wr2");
        chk("scl_period", 32'(rise_t[2] - rise_t[1]), 32'(4 * CLK_DIV));

        // Read three bytes
        txn_data = '{8'h11, 8'h22, 8'h33};
        run_txn(SLV_ADDR, 1'b1, 3, 1'b0, "rd3");

        // Address NACK
        txn_data = '{8'h77, 8'h88};
        run_txn(7'h21, 1'b0, 2, 1'b0, "addr_nack");

        // Probe (also clears the previous nack_err)
        txn_data.delete();
        run_txn(SLV_ADDR, 1'b0, 0, 1'b0, "probe");

        // Reset during the 4th bit of the first write data byte
        txn_data = '{8'hA5, 8'h3C};
        launch(SLV_ADDR, 1'b0, 2);
        w = 0;
        while (mon_rises < 13 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("midrst_reached_bit4", 32'(mon_rises >= 13), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_sclk", 32'(sclk), 32'd1);
        chk("midrst_sda", 32'(sda), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_req_count", 32'(req_cnt), 32'd1);
        txn_data = '{8'h5A};
        run_txn(SLV_ADDR, 1'b0, 1, 1'b0, "after_rst");

        // Start while busy is ignored
        txn_data = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        run_txn(SLV_ADDR, 1'b0, 2, 1'b1, "start_busy");

        // Randomized commands
        for (int t = 0; t < 6; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'h21 : SLV_ADDR;
            rr = 1'($urandom_range(0, 1));
            rn = $urandom_range(1, 4);
            txn_data.delete();
            for (int i = 0; i < rn; i++) txn_data.push_back(8'($urandom_range(0, 255)));
            run_txn(ra, rr, rn, 1'b0, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
